// File: rtl/barrel_shifter_16b.sv
// 16-bit logarithmic barrel shifter: rotate-left, sll, sra, srl by 0-15.
// Combinational result on out, plus a registered copy on out_q.
module barrel_shifter_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic [1:0]  op,
  input  logic [3:0]  shift,
  output logic [15:0] out,
  output logic [15:0] out_q
);

  localparam logic [1:0] OpRol = 2'b00;
  localparam logic [1:0] OpSll = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpSrl = 2'b11;

  // One barrel stage; amt is always a power of two (1, 2, 4 or 8).
  function automatic logic [15:0] shift_stage(input logic [15:0] x, input logic [1:0] sel,
                                              input logic [3:0] amt);
    logic [15:0] r;
    r = x;
    unique case (sel)
      OpRol: r = (x << amt) | (x >> (5'd16 - {1'b0, amt}));
      OpSll: r = x << amt;
      OpSra: r = $signed(x) >>> amt;
      OpSrl: r = x >> amt;
      default: r = x;
    endcase
    return r;
  endfunction

  // Stages run LSB-first; sign fill for sra stays in[15] because bit 15 is preserved.
  always_comb begin
    logic [15:0] acc;
    acc = in;
    for (int k = 0; k < 4; k++) begin
      if (shift[k]) begin
        acc = shift_stage(acc, op, 4'(1 << k));
      end
    end
    out = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_16b.sv
// Self-checking bench for barrel_shifter_16b: directed cases plus randomized
// vectors compared against a behavioural reference model.
module tb_barrel_shifter_16b;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic [1:0]  op;
  logic [3:0]  shift;
  logic [15:0] out;
  logic [15:0] out_q;

  int unsigned checks = 0;
  int unsigned errors = 0;

  barrel_shifter_16b dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .op    (op),
    .shift (shift),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (in=%h op=%0d shift=%0d)", tag, got, exp, in, op,
               shift);
    end
  endtask

  // Reference: rotate via doubled word, shifts via wide arithmetic.
  function automatic logic [15:0] ref_model(input logic [15:0] a, input logic [1:0] o,
                                            input logic [3:0] s);
    logic [31:0] dbl;
    logic [31:0] ext;
    int unsigned n;
    n = s;
    case (o)
      2'b00: begin
        dbl = {a, a};
        return dbl[31 - n -: 16];
      end
      2'b01: return 16'((32'(a) << n) & 32'hFFFF);
      2'b10: begin
        ext = {{16{a[15]}}, a};
        return ext[15:0] >> 0 == 16'h0 && n == 0 ? a : 16'(ext >> n);
      end
      default: return 16'(32'(a) >> n);
    endcase
  endfunction

  task automatic apply(input logic [15:0] a, input logic [1:0] o, input logic [3:0] s);
    in = a;
    op = o;
    shift = s;
    #1;
  endtask

  logic [15:0] exp_prev;
  logic [15:0] exp_cur;

  initial begin
    rst = 1'b1;
    in = '0;
    op = '0;
    shift = '0;

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("reset_out_q", out_q, 16'h0000);

    // Directed combinational cases
    apply(16'h8001, 2'b00, 4'd1);
    check_val("rol_1", out, 16'h0003);
    apply(16'h0001, 2'b00, 4'd15);
    check_val("rol_15", out, 16'h8000);
    apply(16'h8001, 2'b01, 4'd4);
    check_val("sll_4", out, 16'h0010);
    apply(16'h8000, 2'b11, 4'd15);
    check_val("srl_15", out, 16'h0001);
    apply(16'h8000, 2'b10, 4'd15);
    check_val("sra_15_neg", out, 16'hFFFF);
    apply(16'h7F00, 2'b10, 4'd8);
    check_val("sra_8_pos", out, 16'h007F);
    apply(16'h7FFF, 2'b10, 4'd15);
    check_val("sra_15_pos", out, 16'h0000);
    apply(16'hFFFF, 2'b01, 4'd15);
    check_val("sll_15", out, 16'h8000);
    for (int o = 0; o < 4; o++) begin
      apply(16'hA5C3, 2'(o), 4'd0);
      check_val("zero_shift", out, 16'hA5C3);
    end
    check_val("out_q_in_reset", out_q, 16'h0000);

    // Registered path after reset release
    @(negedge clk);
    rst = 1'b0;
    apply(16'h1234, 2'b01, 4'd4);
    @(posedge clk);
    #1;
    check_val("out_q_capture", out_q, 16'h2340);

    // One-edge reset mid-stream, then resume
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("out_q_mid_reset", out_q, 16'h0000);
    check_val("out_during_rst", out, 16'h2340);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("out_q_resume", out_q, 16'h2340);

    // Randomized: first 64 vectors sweep every op/shift pair
    exp_prev = ref_model(in, op, shift);
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      #1;
      check_val("rand_out_q", out_q, exp_prev);
      in = 16'($urandom);
      if (i < 64) begin
        op = 2'(i % 4);
        shift = 4'(i / 4);
      end else begin
        op = 2'($urandom_range(3, 0));
        shift = 4'($urandom_range(15, 0));
      end
      exp_cur = ref_model(in, op, shift);
      @(negedge clk);
      check_val("rand_out", out, exp_cur);
      exp_prev = exp_cur;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_16b.md
Name: barrel_shifter_16b

Overview:
- 16-bit barrel shifter for the datapath execute stage. Performs rotate-left, shift-left-logical, shift-right-arithmetic and shift-right-logical by 0–15 bit positions in a single combinational pass.
- Result is available combinationally on out, and registered on out_q for pipelined consumers.
- Standalone leaf block, instantiated by the ALU.

Parameters:
- none (width fixed at 16, shift amount fixed at 4 bits)

Ports:
- clk    input   1   system clock; out_q updates on rising edge
- rst    input   1   reset, synchronous, active-high
- in     input   16  operand to shift
- op     input   2   operation select (encoding below)
- shift  input   4   shift/rotate amount, 0–15, unsigned
- out    output  16  combinational result
- out_q  output  16  registered result, out captured at each rising clk edge

Interface note: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Operation encoding:
  - op=2'b00 rotate left: bits shifted out of bit 15 re-enter at bit 0.
  - op=2'b01 shift left logical: zeros fill the LSBs.
  - op=2'b10 shift right arithmetic: copies of in[15] fill the MSBs.
  - op=2'b11 shift right logical: zeros fill the MSBs.
- All four encodings are valid; no illegal op exists.
- Structure: 4-stage logarithmic barrel. Stage k shifts by 2^k (1, 2, 4, 8) when shift[k]=1, otherwise passes its input through. Stages are applied in sequence.
- out is purely combinational in in, op and shift. Latency 0: out must settle within the same cycle the inputs change. No dependence on clk or rst.
- shift=0: out == in for every op.
- shift=15 boundaries:
  - rotate-left of a value equals rotate-right by 1.
  - sll leaves only in[0] at bit 15.
  - srl leaves only in[15] at bit 0.
  - sra yields all-ones if in[15]=1, all-zeros otherwise.
- Width rules: no carry-out or overflow flag. Shifted-out bits are discarded, except for rotate.
- out_q:
  - On a rising clk edge with rst=1, out_q <= 16'h0000.
  - Otherwise out_q <= out, sampling the values of in/op/shift present just before the edge.
- Reset:
  - Reset value of out_q is 16'h0000.
  - out is unaffected by rst.
  - Asserting rst mid-stream clears out_q on the next edge only. The edge after rst deasserts resumes capturing out.
- Inputs changing every cycle are legal; there is no handshake and no stall.
- No X propagation permitted: every output bit is driven for every input combination.

Test Plan:
- Rotate: in=16'h8001, op=00, shift=1 -> out=16'h0003. Then in=16'h0001, op=00, shift=15 -> out=16'h8000.
- Logical shifts: in=16'h8001, op=01, shift=4 -> out=16'h0010. Then in=16'h8000, op=11, shift=15 -> out=16'h0001.
- Arithmetic right: in=16'h8000, op=10, shift=15 -> out=16'hFFFF. Then in=16'h7F00, op=10, shift=8 -> out=16'h007F.
- Zero shift: in=16'hA5C3, shift=0, op=00/01/10/11 -> out=16'hA5C3 for each.
- Registered path and reset:
  - rst=1 for 2 edges -> out_q=16'h0000.
  - Release rst, apply in=16'h1234, op=01, shift=4 -> after next rising edge out_q=16'h2340.
  - Reassert rst for one edge -> out_q=16'h0000.
- Randomized: random in/op/shift changed at each posedge, checked at negedge against a reference model. Run ≥1000 vectors covering all ops and all 16 shift amounts. Check out every negedge and out_q against the previous cycle's expected value.
